// File: rtl/cpu_pkg.sv
// Shared types and sizes for the program RAM path and its serial loader.
package cpu_pkg;

  localparam int RAM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + (baud / 2)) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start-glitch rejection, centre sampling.
module uart_rx
  import cpu_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_ferr
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic              sync1_r;
  logic              sync2_r;
  logic              prev_r;
  rx_state_t         state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        bit_r;
  logic [DATA_W-1:0] shift_r;

  // Synchronise the raw line and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Bit-level receive FSM with registered one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RX_IDLE;
      cnt_r    <= '0;
      bit_r    <= 3'd0;
      shift_r  <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          cnt_r <= '0;
          bit_r <= 3'd0;
          if (prev_r && !sync2_r) begin
            state_r <= RX_START;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= '0;
            state_r <= sync2_r ? RX_IDLE : RX_BITS;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_BITS: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r   <= '0;
            shift_r <= {sync2_r, shift_r[DATA_W-1:1]};
            bit_r   <= bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_r <= RX_STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r   <= '0;
            state_r <= RX_IDLE;
            if (sync2_r) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift_r;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Serial program loader: receives SYNC + 16 bytes + checksum, then commits
// the buffered program to the program RAM as 16 back-to-back writes.
module uart_program_loader
  import cpu_pkg::*;
#(
  parameter int          CLK_HZ         = 27_000_000,
  parameter int          BAUD           = 115_200,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 2_700_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              enable,
  output logic              load_active,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(RAM_DEPTH - 1);

  logic              rx_valid_s;
  logic [DATA_W-1:0] rx_byte_s;
  logic              rx_ferr_s;
  logic [DATA_W-1:0] sum_next_s;

  loader_state_t     state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [DATA_W-1:0] sum_r;
  logic [TMO_W-1:0]  tmo_r;
  logic [DATA_W-1:0] mem_r [RAM_DEPTH];

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (uart_rx),
    .rx_valid (rx_valid_s),
    .rx_byte  (rx_byte_s),
    .rx_ferr  (rx_ferr_s)
  );

  assign sum_next_s = sum_r + rx_byte_s;

  // Frame buffer; contents are don't-care until a full frame has arrived.
  always_ff @(posedge clk) begin
    if ((state_r == DATA) && rx_valid_s) begin
      mem_r[idx_r] <= rx_byte_s;
    end
  end

  // Frame FSM with registered RAM-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      sum_r       <= '0;
      tmo_r       <= '0;
      load_active <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      case (state_r)
        IDLE: begin
          idx_r <= '0;
          tmo_r <= '0;
          if (rx_valid_s && enable && (rx_byte_s == SYNC_BYTE)) begin
            state_r     <= DATA;
            sum_r       <= '0;
            error       <= 1'b0;
            load_active <= 1'b1;
          end
        end
        DATA, CHECK: begin
          if (!enable) begin
            state_r     <= IDLE;
            load_active <= 1'b0;
          end else if (rx_ferr_s) begin
            state_r     <= IDLE;
            load_active <= 1'b0;
            error       <= 1'b1;
          end else if (rx_valid_s) begin
            tmo_r <= '0;
            if (state_r == DATA) begin
              sum_r <= sum_next_s;
              idx_r <= idx_r + 4'd1;
              if (idx_r == IDX_LAST) begin
                state_r <= CHECK;
              end
            end else if (sum_next_s == 8'h00) begin
              state_r <= COMMIT;
              idx_r   <= '0;
            end else begin
              state_r     <= IDLE;
              load_active <= 1'b0;
              error       <= 1'b1;
            end
          end else if (tmo_r == TMO_LAST) begin
            state_r     <= IDLE;
            load_active <= 1'b0;
            error       <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TMO_ONE;
          end
        end
        COMMIT: begin
          // The cycle after the last write closes the frame.
          if (wr_en && (wr_addr == IDX_LAST)) begin
            state_r     <= IDLE;
            done        <= 1'b1;
            load_active <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= idx_r;
            wr_data <= mem_r[idx_r];
            idx_r   <= idx_r + 4'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          load_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
